aes_key_gen: RTL and testbench
==============================

# aes_key_gen

AES-128 key-expansion engine producing one round key per enabled clock cycle. The AES-GCM datapath feeds the previous round key back into `pre_rnd_key` together with the round index. The block returns the next round key on a registered output. Eleven enabled cycles (rounds 0..10) yield the full FIPS-197 schedule.

## Interface
- No parameters; AES-128 only (Nk=4, 10 rounds).
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  reset is synchronous and active-low.
- `pre_rnd_key`  input  128  previous round key (round 0: cipher key); bits [127:96] = word w0, byte 0 of each word in its MSBs.
- `i_en_key_gen`  input  1  enable; when high, the register updates this cycle.
- `round_num`  input  4  round index 0..10 selecting the operation/Rcon.
- `next_rnd_key`  output  128  registered round key for `round_num`.

## Operation
- Split `pre_rnd_key` into w0=[127:96], w1=[95:64], w2=[63:32], w3=[31:0].
- RotWord(w3) = {w3[23:0], w3[31:24]} (left rotate one byte).
- SubWord: each of 4 bytes through the AES forward S-box.
- temp = SubWord(RotWord(w3)) XOR {Rcon(round_num), 24'h0}.
- Rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36.
- n0=w0^temp; n1=w1^n0; n2=w2^n1; n3=w3^n2; result={n0,n1,n2,n3}.
- `round_num`==0: result = `pre_rnd_key` unchanged (loads cipher key as round key 0).
- `round_num` 11..15: illegal; register holds its value, no update.
- `i_en_key_gen` low: register holds.
- Entirely combinational from inputs to register D; no internal round counter; the caller sequences `round_num` and closes the feedback loop.

## Timing
- Reset (rst_n low at rising edge): `next_rnd_key` <= 128'h0; overrides enable.
- Latency: 1 cycle; inputs sampled at edge k appear on `next_rnd_key` after edge k.
- Feedback use: caller drives `pre_rnd_key`=`next_rnd_key` combinationally; one new round key per cycle, back-to-back, no bubbles.
- No handshake or busy; enable may drop mid-schedule (hold) and resume with the next `round_num`.
- Reset mid-schedule clears output to 0; caller must restart at round 0.
- The path from `pre_rnd_key` through S-box and 4-deep XOR chain to the register must close at the system clock in one cycle.

## Structure
- Shared package `aes_pkg`: Rcon table/function, AES-128 width constants (key 128, word 32).
- Sub-module `aes_sbox`: combinational 8-bit forward S-box (256-entry case LUT); 4 instances for SubWord. Same module is reused by the cipher datapath.
- Top: word split, rotate, Rcon XOR, XOR chain, round-0/illegal mux, one 128-bit register.

## Test plan
- Reset: hold rst_n low 5 cycles with enable high -> `next_rnd_key`=0 throughout; after release, with enable low, output stays 0.
- Round 0: key 2b7e151628aed2a6abf7158809cf4f3c, round 0, enable -> next cycle output equals the key.
- Full schedule via feedback, rounds 0..10 consecutive cycles -> round1 a0fafe1788542cb123a339392a6c7605, round2 f2c295f27a96b9435935807a7359f67f, round3 3d80477d4716fe3e1e237e446d7a883b, round10 d014f9a8c9ee2589e13f0cc8b6630ca6.
- Enable gap: drop enable for 3 cycles after round 4 -> output holds round-4 key; resuming at round 5 gives the correct round-5 key.
- Illegal round: round_num=11 or 15 with enable -> output unchanged.
- Reset mid-run: assert rst_n low after round 6 -> output 0 next cycle; restart from round 0 reproduces the full schedule.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 width constants and round-constant lookup
package aes_pkg;

  localparam int KEY_W      = 128;
  localparam int WORD_W     = 32;
  localparam int LAST_ROUND = 10;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] rc;
    rc = 8'h00;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, one byte
module aes_sbox (
  input  logic [7:0] addr,
  output logic [7:0] data
);

  always_comb begin
    data = 8'h00;
    case (addr)
      8'h00: data = 8'h63; 8'h01: data = 8'h7c; 8'h02: data = 8'h77; 8'h03: data = 8'h7b; 8'h04: data = 8'hf2; 8'h05: data = 8'h6b; 8'h06: data = 8'h6f; 8'h07: data = 8'hc5;
      8'h08: data = 8'h30; 8'h09: data = 8'h01; 8'h0a: data = 8'h67; 8'h0b: data = 8'h2b; 8'h0c: data = 8'hfe; 8'h0d: data = 8'hd7; 8'h0e: data = 8'hab; 8'h0f: data = 8'h76;
      8'h10: data = 8'hca; 8'h11: data = 8'h82; 8'h12: data = 8'hc9; 8'h13: data = 8'h7d; 8'h14: data = 8'hfa; 8'h15: data = 8'h59; 8'h16: data = 8'h47; 8'h17: data = 8'hf0;
      8'h18: data = 8'had; 8'h19: data = 8'hd4; 8'h1a: data = 8'ha2; 8'h1b: data = 8'haf; 8'h1c: data = 8'h9c; 8'h1d: data = 8'ha4; 8'h1e: data = 8'h72; 8'h1f: data = 8'hc0;
      8'h20: data = 8'hb7; 8'h21: data = 8'hfd; 8'h22: data = 8'h93; 8'h23: data = 8'h26; 8'h24: data = 8'h36; 8'h25: data = 8'h3f; 8'h26: data = 8'hf7; 8'h27: data = 8'hcc;
      8'h28: data = 8'h34; 8'h29: data = 8'ha5; 8'h2a: data = 8'he5; 8'h2b: data = 8'hf1; 8'h2c: data = 8'h71; 8'h2d: data = 8'hd8; 8'h2e: data = 8'h31; 8'h2f: data = 8'h15;
      8'h30: data = 8'h04; 8'h31: data = 8'hc7; 8'h32: data = 8'h23; 8'h33: data = 8'hc3; 8'h34: data = 8'h18; 8'h35: data = 8'h96; 8'h36: data = 8'h05; 8'h37: data = 8'h9a;
      8'h38: data = 8'h07; 8'h39: data = 8'h12; 8'h3a: data = 8'h80; 8'h3b: data = 8'he2; 8'h3c: data = 8'heb; 8'h3d: data = 8'h27; 8'h3e: data = 8'hb2; 8'h3f: data = 8'h75;
      8'h40: data = 8'h09; 8'h41: data = 8'h83; 8'h42: data = 8'h2c; 8'h43: data = 8'h1a; 8'h44: data = 8'h1b; 8'h45: data = 8'h6e; 8'h46: data = 8'h5a; 8'h47: data = 8'ha0;
      8'h48: data = 8'h52; 8'h49: data = 8'h3b; 8'h4a: data = 8'hd6; 8'h4b: data = 8'hb3; 8'h4c: data = 8'h29; 8'h4d: data = 8'he3; 8'h4e: data = 8'h2f; 8'h4f: data = 8'h84;
      8'h50: data = 8'h53; 8'h51: data = 8'hd1; 8'h52: data = 8'h00; 8'h53: data = 8'hed; 8'h54: data = 8'h20; 8'h55: data = 8'hfc; 8'h56: data = 8'hb1; 8'h57: data = 8'h5b;
      8'h58: data = 8'h6a; 8'h59: data = 8'hcb; 8'h5a: data = 8'hbe; 8'h5b: data = 8'h39; 8'h5c: data = 8'h4a; 8'h5d: data = 8'h4c; 8'h5e: data = 8'h58; 8'h5f: data = 8'hcf;
      8'h60: data = 8'hd0; 8'h61: data = 8'hef; 8'h62: data = 8'haa; 8'h63: data = 8'hfb; 8'h64: data = 8'h43; 8'h65: data = 8'h4d; 8'h66: data = 8'h33; 8'h67: data = 8'h85;
      8'h68: data = 8'h45; 8'h69: data = 8'hf9; 8'h6a: data = 8'h02; 8'h6b: data = 8'h7f; 8'h6c: data = 8'h50; 8'h6d: data = 8'h3c; 8'h6e: data = 8'h9f; 8'h6f: data = 8'ha8;
      8'h70: data = 8'h51; 8'h71: data = 8'ha3; 8'h72: data = 8'h40; 8'h73: data = 8'h8f; 8'h74: data = 8'h92; 8'h75: data = 8'h9d; 8'h76: data = 8'h38; 8'h77: data = 8'hf5;
      8'h78: data = 8'hbc; 8'h79: data = 8'hb6; 8'h7a: data = 8'hda; 8'h7b: data = 8'h21; 8'h7c: data = 8'h10; 8'h7d: data = 8'hff; 8'h7e: data = 8'hf3; 8'h7f: data = 8'hd2;
      8'h80: data = 8'hcd; 8'h81: data = 8'h0c; 8'h82: data = 8'h13; 8'h83: data = 8'hec; 8'h84: data = 8'h5f; 8'h85: data = 8'h97; 8'h86: data = 8'h44; 8'h87: data = 8'h17;
      8'h88: data = 8'hc4; 8'h89: data = 8'ha7; 8'h8a: data = 8'h7e; 8'h8b: data = 8'h3d; 8'h8c: data = 8'h64; 8'h8d: data = 8'h5d; 8'h8e: data = 8'h19; 8'h8f: data = 8'h73;
      8'h90: data = 8'h60; 8'h91: data = 8'h81; 8'h92: data = 8'h4f; 8'h93: data = 8'hdc; 8'h94: data = 8'h22; 8'h95: data = 8'h2a; 8'h96: data = 8'h90; 8'h97: data = 8'h88;
      8'h98: data = 8'h46; 8'h99: data = 8'hee; 8'h9a: data = 8'hb8; 8'h9b: data = 8'h14; 8'h9c: data = 8'hde; 8'h9d: data = 8'h5e; 8'h9e: data = 8'h0b; 8'h9f: data = 8'hdb;
      8'ha0: data = 8'he0; 8'ha1: data = 8'h32; 8'ha2: data = 8'h3a; 8'ha3: data = 8'h0a; 8'ha4: data = 8'h49; 8'ha5: data = 8'h06; 8'ha6: data = 8'h24; 8'ha7: data = 8'h5c;
      8'ha8: data = 8'hc2; 8'ha9: data = 8'hd3; 8'haa: data = 8'hac; 8'hab: data = 8'h62; 8'hac: data = 8'h91; 8'had: data = 8'h95; 8'hae: data = 8'he4; 8'haf: data = 8'h79;
      8'hb0: data = 8'he7; 8'hb1: data = 8'hc8; 8'hb2: data = 8'h37; 8'hb3: data = 8'h6d; 8'hb4: data = 8'h8d; 8'hb5: data = 8'hd5; 8'hb6: data = 8'h4e; 8'hb7: data = 8'ha9;
      8'hb8: data = 8'h6c; 8'hb9: data = 8'h56; 8'hba: data = 8'hf4; 8'hbb: data = 8'hea; 8'hbc: data = 8'h65; 8'hbd: data = 8'h7a; 8'hbe: data = 8'hae; 8'hbf: data = 8'h08;
      8'hc0: data = 8'hba; 8'hc1: data = 8'h78; 8'hc2: data = 8'h25; 8'hc3: data = 8'h2e; 8'hc4: data = 8'h1c; 8'hc5: data = 8'ha6; 8'hc6: data = 8'hb4; 8'hc7: data = 8'hc6;
      8'hc8: data = 8'he8; 8'hc9: data = 8'hdd; 8'hca: data = 8'h74; 8'hcb: data = 8'h1f; 8'hcc: data = 8'h4b; 8'hcd: data = 8'hbd; 8'hce: data = 8'h8b; 8'hcf: data = 8'h8a;
      8'hd0: data = 8'h70; 8'hd1: data = 8'h3e; 8'hd2: data = 8'hb5; 8'hd3: data = 8'h66; 8'hd4: data = 8'h48; 8'hd5: data = 8'h03; 8'hd6: data = 8'hf6; 8'hd7: data = 8'h0e;
      8'hd8: data = 8'h61; 8'hd9: data = 8'h35; 8'hda: data = 8'h57; 8'hdb: data = 8'hb9; 8'hdc: data = 8'h86; 8'hdd: data = 8'hc1; 8'hde: data = 8'h1d; 8'hdf: data = 8'h9e;
      8'he0: data = 8'he1; 8'he1: data = 8'hf8; 8'he2: data = 8'h98; 8'he3: data = 8'h11; 8'he4: data = 8'h69; 8'he5: data = 8'hd9; 8'he6: data = 8'h8e; 8'he7: data = 8'h94;
      8'he8: data = 8'h9b; 8'he9: data = 8'h1e; 8'hea: data = 8'h87; 8'heb: data = 8'he9; 8'hec: data = 8'hce; 8'hed: data = 8'h55; 8'hee: data = 8'h28; 8'hef: data = 8'hdf;
      8'hf0: data = 8'h8c; 8'hf1: data = 8'ha1; 8'hf2: data = 8'h89; 8'hf3: data = 8'h0d; 8'hf4: data = 8'hbf; 8'hf5: data = 8'he6; 8'hf6: data = 8'h42; 8'hf7: data = 8'h68;
      8'hf8: data = 8'h41; 8'hf9: data = 8'h99; 8'hfa: data = 8'h2d; 8'hfb: data = 8'h0f; 8'hfc: data = 8'hb0; 8'hfd: data = 8'h54; 8'hfe: data = 8'hbb; 8'hff: data = 8'h16;
      default: data = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes_key_gen.sv
// rtl/aes_key_gen.sv - AES-128 key expansion, one registered round key per enabled cycle
module aes_key_gen
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KEY_W-1:0]  pre_rnd_key,
  input  logic              i_en_key_gen,
  input  logic [3:0]        round_num,
  output logic [KEY_W-1:0]  next_rnd_key
);

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] rot, sub, temp;
  logic [WORD_W-1:0] n0, n1, n2, n3;
  logic [KEY_W-1:0]  d;

  assign {w0, w1, w2, w3} = pre_rnd_key;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .addr (rot[8*i +: 8]),
      .data (sub[8*i +: 8])
    );
  end

  assign temp = sub ^ {rcon(round_num), 24'h0};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;

  // Round 0 passes the cipher key through; rounds past the last one hold the register.
  always_comb begin
    d = next_rnd_key;
    if (round_num == 4'd0) begin
      d = pre_rnd_key;
    end else if (round_num <= 4'(LAST_ROUND)) begin
      d = {n0, n1, n2, n3};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      next_rnd_key <= '0;
    end else if (i_en_key_gen) begin
      next_rnd_key <= d;
    end
  end

endmodule

// File: tb/tb_aes_key_gen.sv
// tb/tb_aes_key_gen.sv - randomized self-checking bench for aes_key_gen
module tb_aes_key_gen;

  localparam logic [127:0] CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R2    = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] FIPS_R3    = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] FIPS_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [3:0]   round_num;
  logic [127:0] key_in;
  logic         fb;
  logic [127:0] pre;
  logic [127:0] next_rnd_key;

  logic [127:0] model_q;
  logic [7:0]   sbox_ref [256];
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  assign pre = fb ? next_rnd_key : key_in;

  aes_key_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pre_rnd_key  (pre),
    .i_en_key_gen (en),
    .round_num    (round_num),
    .next_rnd_key (next_rnd_key)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%032h want=%032h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] rcon_ref(input int r);
    logic [7:0] rc = 8'h01;
    for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
    return rc;
  endfunction

  // One step of the FIPS-197 schedule, worked on an array of words.
  function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
    logic [31:0] w [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    t = {sbox_ref[w[3][23:16]], sbox_ref[w[3][15:8]], sbox_ref[w[3][7:0]], sbox_ref[w[3][31:24]]};
    t[31:24] ^= rcon_ref(r);
    w[0] ^= t;
    for (int i = 1; i < 4; i++) w[i] ^= w[i-1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  task automatic cycle(input string tag);
    logic [127:0] pre_m;
    logic [127:0] want;
    pre_m = fb ? model_q : key_in;
    want  = model_q;
    if (!rst_n) want = '0;
    else if (en && round_num <= 4'd10) want = (round_num == 4'd0) ? pre_m : next_key(pre_m, int'(round_num));
    @(posedge clk);
    #1;
    model_q = want;
    check(tag, next_rnd_key, model_q);
  endtask

  task automatic run_rounds(input int first, input int last);
    for (int r = first; r <= last; r++) begin
      fb        = (r != 0);
      key_in    = CIPHER_KEY;
      round_num = 4'(r);
      en        = 1'b1;
      cycle($sformatf("sched_r%0d", r));
      if (r == 1)  check("fips_r1", next_rnd_key, FIPS_R1);
      if (r == 2)  check("fips_r2", next_rnd_key, FIPS_R2);
      if (r == 3)  check("fips_r3", next_rnd_key, FIPS_R3);
      if (r == 10) check("fips_r10", next_rnd_key, FIPS_R10);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    model_q   = '0;
    rst_n     = 1'b0;
    en        = 1'b1;
    fb        = 1'b0;
    round_num = 4'd0;
    key_in    = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    for (int i = 0; i < 5; i++) cycle("reset_hold");
    rst_n = 1'b1;
    en    = 1'b0;
    for (int i = 0; i < 2; i++) cycle("post_reset_idle");

    key_in    = CIPHER_KEY;
    round_num = 4'd0;
    en        = 1'b1;
    cycle("round0_load");
    check("round0_key", next_rnd_key, CIPHER_KEY);

    run_rounds(1, 10);

    run_rounds(0, 4);
    en = 1'b0;
    fb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      round_num = 4'($urandom_range(0, 15));
      cycle("enable_gap_hold");
    end
    run_rounds(5, 10);

    fb = 1'b0;
    en = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    round_num = 4'd11;
    cycle("illegal_r11");
    round_num = 4'd15;
    cycle("illegal_r15");

    run_rounds(0, 6);
    rst_n = 1'b0;
    cycle("mid_reset");
    check("mid_reset_zero", next_rnd_key, 128'h0);
    rst_n = 1'b1;
    run_rounds(0, 10);

    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 31) != 0);
      en        = ($urandom_range(0, 3) != 0);
      fb        = $urandom_range(0, 1) == 1;
      round_num = 4'($urandom_range(0, 15));
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
